// File: rtl/tdm_demux4_if.sv
// Link-side bundle for the 4-lane TDM demultiplexer: beat input plus assembled-word output.
// The master drives beats and observes the word; the slave is the demux itself.
interface tdm_demux4_if #(
    parameter int LANE_W = 1
);
    logic [LANE_W-1:0]   din;
    logic                din_valid;
    logic                frame_start;
    logic [4*LANE_W-1:0] dout;
    logic                dout_valid;
    logic [1:0]          slot;
    logic                synced;
    logic                align_err;
    logic                par_err;

    modport master (
        output din, din_valid, frame_start,
        input  dout, dout_valid, slot, synced, align_err, par_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output dout, dout_valid, slot, synced, align_err, par_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of the 4-lane TDM link: routes beats to lane[slot] and emits whole words.
// Optional trailing even-parity beat per frame when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux4 #(
    parameter int LANE_W = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    tdm_demux4_if.slave   bus
);
    typedef enum logic [1:0] {HUNT = 2'd0, RUN = 2'd1, PAR = 2'd2} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                slot_q, slot_d;
    logic [3:0][LANE_W-1:0]    shadow_q, shadow_d;
    logic [4*LANE_W-1:0]       dout_q, dout_d;
    logic [4*LANE_W-1:0]       word;
    logic                      dv_q, dv_d;
    logic                      ae_q, ae_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic                      pe_q, pe_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            slot_q   <= 2'd0;
            shadow_q <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            ae_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            ae_q     <= ae_d;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q     <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        ae_d     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        pe_d     = 1'b0;
        word     = shadow_q;
`else
        // Lane 3 goes straight to dout so the word completes on the slot-3 beat.
        word     = {bus.din, shadow_q[2:0]};
`endif
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_start) begin
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_start && slot_q != 2'd0) begin
                        ae_d        = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                    end else begin
                        shadow_d[slot_q] = bus.din;
                        if (slot_q == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
                            state_d = PAR;
`else
                            dout_d  = word;
                            dv_d    = 1'b1;
                            slot_d  = 2'd0;
`endif
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    if (bus.frame_start) begin
                        ae_d        = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                        state_d     = RUN;
                    end else if (bus.din[0] == ^word) begin
                        dout_d  = word;
                        dv_d    = 1'b1;
                        slot_d  = 2'd0;
                        state_d = RUN;
                    end else begin
                        pe_d    = 1'b1;
                        slot_d  = 2'd0;
                        state_d = HUNT;
                    end
                end
`endif
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus.dout       = dout_q;
        bus.dout_valid = dv_q;
        bus.slot       = slot_q;
        bus.synced     = (state_q != HUNT);
        bus.align_err  = ae_q;
`ifdef TDM_DEMUX_PARITY_EN
        bus.par_err    = pe_q;
`else
        bus.par_err    = 1'b0;
`endif
    end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the team's 4-lane time-division link; the transmit side serialises lanes with the 4-input mux steered by a 2-bit select.
- Takes one lane beat per valid cycle, routes it to lane[slot] (the inverse of the mux select), and assembles a full 4-lane word.
- Presents the word in parallel with a one-cycle valid pulse.
- Detects and recovers from frame misalignment.

Parameters:
- LANE_W, 1, bits per lane beat; the output word is 4*LANE_W bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- din  input  LANE_W  lane beat from the link
- din_valid  input  1  din carries a beat this cycle
- frame_start  input  1  qualified by din_valid; marks the slot-0 beat
- dout  output  4*LANE_W  assembled word; lane k at bits [k*LANE_W +: LANE_W]
- dout_valid  output  1  one-cycle pulse: dout holds a new word
- slot  output  2  lane index the next accepted beat will fill
- synced  output  1  high while in RUN
- align_err  output  1  one-cycle pulse: frame_start seen mid-frame
- par_err  output  1  parity failure pulse; constant 0 unless TDM_DEMUX_PARITY_EN

Behaviour:
- Reset: clk and rst_n are fixed as one clock with synchronous active-low reset. rst_n low at a clk edge clears:
  - dout=0, dout_valid=0, slot=0, synced=0, align_err=0, par_err=0
  - state=HUNT; the partial-word shadow register is cleared.
- Reset mid-frame discards the partial word. No dout_valid for that frame.
- Beat accepted = din_valid high at a clk edge. Cycles with din_valid low change nothing except clearing the pulse outputs.
- States:
  - HUNT:
    - Beats without frame_start are dropped.
    - A beat with frame_start writes shadow lane 0, sets slot=1, goes to RUN, sets synced=1.
  - RUN, beat without frame_start:
    - Writes shadow lane[slot], then slot=slot+1 (wraps 3->0).
    - On the slot-3 beat: dout <= {din, shadow lanes 2..0} and dout_valid=1 on the following cycle.
    - Latency is 1 clk from the slot-3 beat edge to dout_valid high.
  - RUN, beat with frame_start at slot=0: normal slot-0 beat. frame_start is optional once synced.
  - RUN, beat with frame_start at slot!=0:
    - Partial frame discarded; align_err pulses next cycle.
    - The beat is taken as the new lane 0, and slot=1. Stays in RUN.
- dout holds its last value between words. It is never partially updated.
- dout_valid and align_err are single-cycle pulses and never stretched; back-to-back frames give a dout_valid pulse every 4 accepted beats.
- No backpressure: the downstream must consume the word on the dout_valid cycle or lose it. dout is stable until the next completed word.
- Lane beats are stored verbatim; no arithmetic on data.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - A fifth beat follows lane 3, in state PAR. slot stays 3 during PAR.
  - din[0] of the PAR beat must equal the XOR-reduction of the 4*LANE_W assembled bits (even parity).
  - Match: dout updates and dout_valid pulses 1 clk after the PAR beat.
  - Mismatch: word discarded, dout unchanged, par_err pulses 1 clk after, and the FSM returns to HUNT with synced=0.
  - frame_start on the PAR beat is treated as misalignment, identical to the RUN mid-frame case.
- Undefined: no PAR state; par_err tied 0; 4-beat frames as above.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with din_valid=1 -> dout=0, dout_valid=0, slot=0, synced=0. All outputs stay 0 for 1 clk after release with din_valid=0.
- Basic frame (LANE_W=1):
  - Stimulus: beats 1 (frame_start), 0, 1, 1.
  - Response: dout=4'b1101 with dout_valid high exactly 1 clk after the 4th beat; slot sequence 1,2,3,0.
- Gapped input: same frame as the basic case, with din_valid=0 for 3 cycles between each beat -> identical dout=4'b1101, still a single dout_valid pulse.
- Hunt: 3 beats without frame_start, then frame 0,1,0,1 (frame_start on the first) -> synced rises after the 4th cycle's beat; dout=4'b1010; the earlier beats are ignored.
- Misalign:
  - Stimulus: in RUN after 2 beats (slot=2), a beat with frame_start and din=1, then beats 0, 0, 1.
  - Response: align_err pulse, no dout_valid for the aborted frame, then dout=4'b1001.
- Parity (TDM_DEMUX_PARITY_EN):
  - Frame 1,1,1,0 with PAR=1 -> dout=4'b0111, dout_valid pulses.
  - Same frame with PAR=0 -> par_err pulses, dout unchanged, synced=0.
